// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern sequencer: prescaled tick drives one of five patterns.
// Optional PWM brightness gating is built only when LED_PWM_EN is defined.
module led_pattern_gen #(
    parameter int N_LED = 8,
    parameter int DIV   = 25000000,
    parameter int CW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [1:0]       speed,
    input  logic [3:0]       bri,
    output logic [N_LED-1:0] led,
    output logic             step
);

    typedef enum logic { DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1 } dir_t;

    localparam logic [CW-1:0]    DIV_W   = CW'(DIV);
    localparam logic [N_LED-1:0] PAT_TOP = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [N_LED-1:0] PAT_ONE = {{(N_LED-1){1'b0}}, 1'b1};

    logic [N_LED-1:0] pat_q, pat_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    dir_t             dir_q, dir_d;
    logic             fill_q, fill_d;
    logic [2:0]       mode_q;
    logic             step_q, step_d;

    logic [CW-1:0]    period;
    logic             tick;
    logic             reload;
    logic [N_LED-1:0] bar_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= PAT_TOP;
            cnt_q  <= '0;
            dir_q  <= DIR_RIGHT;
            fill_q <= 1'b1;
            mode_q <= 3'd0;
            step_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            fill_q <= fill_d;
            mode_q <= mode;
            step_q <= step_d;
        end
    end

    // >= rather than == so a mid-count speed-up ticks next cycle instead of wrapping.
    always_comb begin
        period   = DIV_W >> speed;
        tick     = en && (cnt_q >= period - 1'b1);
        reload   = (mode != mode_q);
        bar_next = {fill_q, pat_q[N_LED-1:1]};

        pat_d  = pat_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        fill_d = fill_q;
        step_d = 1'b0;

        if (reload) begin
            cnt_d  = '0;
            dir_d  = DIR_RIGHT;
            fill_d = 1'b1;
            case (mode)
                3'd0, 3'd2, 3'd4: pat_d = PAT_TOP;
                3'd1:             pat_d = PAT_ONE;
                3'd3:             pat_d = '0;
                default:          pat_d = pat_q;
            endcase
        end else if (tick) begin
            cnt_d  = '0;
            step_d = 1'b1;
            case (mode_q)
                3'd0: pat_d = {pat_q[0], pat_q[N_LED-1:1]};
                3'd1: pat_d = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
                3'd2: begin
                    // The dot reaches an endpoint on this shift; turn around for the next one.
                    if (dir_q == DIR_RIGHT) begin
                        pat_d = pat_q >> 1;
                        if (pat_q[1]) dir_d = DIR_LEFT;
                    end else begin
                        pat_d = pat_q << 1;
                        if (pat_q[N_LED-2]) dir_d = DIR_RIGHT;
                    end
                end
                3'd3: pat_d = pat_q + 1'b1;
                3'd4: begin
                    pat_d = bar_next;
                    if (fill_q && (&bar_next)) fill_d = 1'b0;
                    if (!fill_q && (bar_next == '0)) fill_d = 1'b1;
                end
                default: pat_d = pat_q;
            endcase
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign step = step_q;

`ifdef LED_PWM_EN
    logic [3:0]       pwm_q;
    logic [N_LED-1:0] led_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_q <= 4'd0;
            led_q <= '0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
            led_q <= pat_q & {N_LED{pwm_q < bri}};
        end
    end

    assign led = led_q;
`else
    logic unused_bri;
    assign unused_bri = ^bri;
    assign led        = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (N_LED=8, DIV=8): expected LED values are queued
// by the stimulus and checked by a monitor on every step pulse.
module tb_led_pattern_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [1:0] speed;
    logic [3:0] bri;
    logic [7:0] led;
    logic       step;

    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_fail;

    led_pattern_gen #(.N_LED(8), .DIV(8), .CW(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .speed (speed),
        .bri   (bri),
        .led   (led),
        .step  (step)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // monitor: each step pulse presents a new pattern
    always @(negedge clk) begin
        if (rst && step) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL step_unexpected: led=%02h with no expected value queued", led);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (led !== e) begin
                    n_fail++;
                    $display("FAIL step_led: got %02h expected %02h", led, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, got, want);
        end
    endtask

    // queue an expected pattern and confirm the step arrives after exactly cyc clocks
    task automatic expect_tick(input int cyc, input logic [7:0] v);
        int k;
        bit seen;
        exp_q.push_back(v);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 64) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (step) seen = 1'b1;
        end
        n_checks++;
        if (!seen || k != cyc) begin
            n_fail++;
            $display("FAIL tick_latency: got %0d cycles (seen=%0d) expected %0d", k, seen, cyc);
        end
    endtask

    task automatic do_reload(input logic [2:0] m, input logic [1:0] s, input logic [7:0] seed);
        mode  = m;
        speed = s;
        @(posedge clk);
        @(negedge clk);
        check("reload_step", {7'd0, step}, 8'd0);
        check("reload_seed", led, seed);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] v;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b0;
        en    = 1'b1;
        mode  = 3'd0;
        speed = 2'd0;
        bri   = 4'd0;

        // reset state
        idle(3);
        check("reset_led", led, 8'h80);
        check("reset_step", {7'd0, step}, 8'd0);
        rst = 1'b1;

        // rotate right, P=8
        v = 8'h80;
        for (int i = 0; i < 8; i++) begin
            v = {v[0], v[7:1]};
            expect_tick(8, v);
        end
        check("rot_right_home", led, 8'h80);

        // bounce, P=2
        do_reload(3'd2, 2'd2, 8'h80);
        expect_tick(2, 8'h40); expect_tick(2, 8'h20); expect_tick(2, 8'h10);
        expect_tick(2, 8'h08); expect_tick(2, 8'h04); expect_tick(2, 8'h02);
        expect_tick(2, 8'h01); expect_tick(2, 8'h02); expect_tick(2, 8'h04);
        expect_tick(2, 8'h08); expect_tick(2, 8'h10); expect_tick(2, 8'h20);
        expect_tick(2, 8'h40); expect_tick(2, 8'h80); expect_tick(2, 8'h40);

        // binary count, P=1, reload wins over the coincident tick
        do_reload(3'd3, 2'd3, 8'h00);
        for (int i = 1; i <= 256; i++) begin
            v = 8'(i);
            expect_tick(1, v);
        end

        // bar fill/drain, P=2
        do_reload(3'd4, 2'd2, 8'h80);
        expect_tick(2, 8'hC0); expect_tick(2, 8'hE0); expect_tick(2, 8'hF0);
        expect_tick(2, 8'hF8); expect_tick(2, 8'hFC); expect_tick(2, 8'hFE);
        expect_tick(2, 8'hFF); expect_tick(2, 8'h7F); expect_tick(2, 8'h3F);
        expect_tick(2, 8'h1F); expect_tick(2, 8'h0F); expect_tick(2, 8'h07);
        expect_tick(2, 8'h03); expect_tick(2, 8'h01); expect_tick(2, 8'h00);
        expect_tick(2, 8'h80);

        // freeze with en=0 at cnt=3, then the remaining 5 cycles complete
        do_reload(3'd0, 2'd0, 8'h80);
        idle(3);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (i % 5 == 4) check("frozen_led", led, 8'h80);
        end
        en = 1'b1;
        expect_tick(5, 8'h40);

        // speed-up at cnt=6: tick next cycle, no wrap-around
        idle(6);
        speed = 2'd3;
        expect_tick(1, 8'h20);
        expect_tick(1, 8'h10);

        // hold mode keeps the pattern but still steps
        do_reload(3'd5, 2'd3, 8'h10);
        expect_tick(1, 8'h10);
        expect_tick(1, 8'h10);

        // rotate left
        do_reload(3'd1, 2'd3, 8'h01);
        v = 8'h01;
        for (int i = 0; i < 8; i++) begin
            v = {v[6:0], v[7]};
            expect_tick(1, v);
        end

        // asynchronous reset mid-count
        do_reload(3'd0, 2'd0, 8'h80);
        idle(2);
        expect_tick(6, 8'h40);
        idle(3);
        #2 rst = 1'b0;
        #1;
        check("async_reset_led", led, 8'h80);
        check("async_reset_step", {7'd0, step}, 8'd0);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
